// File: rtl/wb_drain_if.sv
// Memory write bus between the write-buffer drain controller (master) and the memory port (slave).
interface wb_drain_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_err
    );
endinterface

// File: rtl/wb_drain.sv
// Write-buffer drain: pops {addr,data} stores from the FIFO head and writes them to memory,
// retrying failed writes after a fixed backoff and dropping an entry once retries run out.
module wb_drain #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 4,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W+DATA_W-1:0] fifo_data,
    input  logic [CNT_W-1:0]         fifo_cnt,
    output logic                     fifo_pop,
    input  logic                     pause,
    wb_drain_if.master               mem,
    output logic                     busy,
    output logic                     drained,
    output logic                     drop_err,
    input  logic                     err_clr,
    output logic [15:0]              wr_count
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BACKOFF} state_t;

    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);
    localparam logic [7:0] BACKOFF_C   = 8'(BACKOFF);

    state_t            state, state_nxt;
    logic [3:0]        retry_cnt;
    logic [7:0]        backoff_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pop, wr_ok, wr_retry, wr_drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        wr_ok     = 1'b0;
        wr_retry  = 1'b0;
        wr_drop   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fifo_cnt != '0 && !pause) begin
                    pop       = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    if (!mem.mem_err) begin
                        wr_ok     = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (retry_cnt < MAX_RETRY_C) begin
                        wr_retry  = 1'b1;
                        state_nxt = S_BACKOFF;
                    end else begin
                        wr_drop   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_BACKOFF: begin
                if (backoff_cnt == 8'd1) state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            retry_cnt   <= '0;
            backoff_cnt <= '0;
            wr_count    <= '0;
            drop_err    <= 1'b0;
        end else begin
            if (pop) begin
                addr_q    <= fifo_data[ADDR_W+DATA_W-1:DATA_W];
                wdata_q   <= fifo_data[DATA_W-1:0];
                retry_cnt <= '0;
            end
            if (wr_retry) begin
                retry_cnt   <= retry_cnt + 4'd1;
                backoff_cnt <= BACKOFF_C;
            end else if (state == S_BACKOFF) begin
                backoff_cnt <= backoff_cnt - 8'd1;
            end
            if (wr_ok) wr_count <= wr_count + 16'd1;
            if (wr_drop)      drop_err <= 1'b1;
            else if (err_clr) drop_err <= 1'b0;
        end
    end

    // A pop while reset is held would remove an entry that never gets latched.
    assign fifo_pop      = pop & reset_n;
    assign mem.mem_req   = (state == S_REQ);
    assign mem.mem_we    = (state == S_REQ);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign busy          = (state != S_IDLE);
    assign drained       = (state == S_IDLE) && (fifo_cnt == '0);
endmodule

// File: tb/tb_wb_drain.sv
// Randomized bench for wb_drain: queue-based FIFO and memory responder, checked against a
// transaction-level model of entries, attempts, backoff gaps and counters.
module tb_wb_drain;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 4;
    localparam int MAX_RETRY = 3;
    localparam int BACKOFF   = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                n_err;
    } entry_t;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [ADDR_W+DATA_W-1:0] fifo_data;
    logic [CNT_W-1:0]         fifo_cnt;
    logic                     fifo_pop;
    logic                     pause;
    logic                     busy;
    logic                     drained;
    logic                     drop_err;
    logic                     err_clr;
    logic [15:0]              wr_count;

    wb_drain_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_drain #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .fifo_data(fifo_data),
        .fifo_cnt (fifo_cnt),
        .fifo_pop (fifo_pop),
        .pause    (pause),
        .mem      (bus),
        .busy     (busy),
        .drained  (drained),
        .drop_err (drop_err),
        .err_clr  (err_clr),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Model state: FIFO contents, entry in flight, attempt number, remaining backoff gap.
    entry_t      fifo_q[$];
    entry_t      cur;
    bit          exp_busy;
    bit          exp_drop;
    logic [15:0] exp_wr;
    int          attempt;
    int          backoff_left;
    bit          att_active;
    int          wait_left;
    int          fixed_lat;
    int          pops;
    int          req_cycles;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_cnt  = CNT_W'(fifo_q.size());
        fifo_data = (fifo_q.size() != 0) ? {fifo_q[0].addr, fifo_q[0].data} : '0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int n_err);
        entry_t e;
        e.addr  = a;
        e.data  = d;
        e.n_err = n_err;
        fifo_q.push_back(e);
        drive_fifo();
    endtask

    task automatic model_reset();
        exp_busy     = 1'b0;
        exp_drop     = 1'b0;
        exp_wr       = '0;
        attempt      = 0;
        backoff_left = 0;
        att_active   = 1'b0;
        wait_left    = 0;
    endtask

    // One clock: check outputs, play the memory side, cross the edge, advance the model.
    task automatic cycle();
        bit do_ack, was_err, popping, drop_now;
        #1;
        check("busy", busy, exp_busy);
        check("drained", drained, !exp_busy && fifo_q.size() == 0);
        check("wr_count", wr_count, exp_wr);
        check("drop_err", drop_err, exp_drop);
        check("mem_we", bus.mem_we, exp_busy && backoff_left == 0);
        check("mem_req", bus.mem_req, exp_busy && backoff_left == 0);
        check("fifo_pop", fifo_pop, !exp_busy && fifo_q.size() != 0 && !pause);
        do_ack      = 1'b0;
        was_err     = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'($urandom_range(0, 1));
        if (exp_busy && backoff_left == 0) begin
            check("mem_addr", bus.mem_addr, cur.addr);
            check("mem_wdata", bus.mem_wdata, cur.data);
            req_cycles++;
            if (!att_active) begin
                att_active = 1'b1;
                wait_left  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (wait_left == 0) begin
                do_ack      = 1'b1;
                was_err     = (attempt < cur.n_err);
                bus.mem_ack = 1'b1;
                bus.mem_err = was_err;
            end else begin
                wait_left--;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            bus.mem_ack = 1'b1;
        end
        popping = fifo_pop;
        if (popping) pops++;
        @(posedge clk);
        #1;
        drop_now = 1'b0;
        if (backoff_left > 0) backoff_left--;
        if (do_ack) begin
            att_active = 1'b0;
            if (!was_err) begin
                exp_wr++;
                exp_busy = 1'b0;
            end else begin
                attempt++;
                if (attempt > MAX_RETRY) begin
                    drop_now = 1'b1;
                    exp_busy = 1'b0;
                end else begin
                    backoff_left = BACKOFF;
                end
            end
        end
        if (drop_now)     exp_drop = 1'b1;
        else if (err_clr) exp_drop = 1'b0;
        if (popping) begin
            cur          = fifo_q.pop_front();
            exp_busy     = 1'b1;
            attempt      = 0;
            att_active   = 1'b0;
            backoff_left = 0;
        end
        drive_fifo();
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cycles, output int used);
        used = 0;
        do begin
            cycle();
            used++;
        end while ((exp_busy || fifo_q.size() != 0) && used < max_cycles);
        check("drain_timeout", 64'(exp_busy || fifo_q.size() != 0), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int used, p0, r0;
        logic [15:0] w0;
        n_checks    = 0;
        n_fail      = 0;
        pops        = 0;
        req_cycles  = 0;
        fixed_lat   = -1;
        pause       = 1'b0;
        err_clr     = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'b0;
        reset_n     = 1'b0;
        model_reset();
        drive_fifo();

        // Reset state with an empty FIFO.
        repeat (2) @(posedge clk);
        #2;
        check("rst_drained", drained, 1);
        check("rst_busy", busy, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_wr_count", wr_count, 0);
        reset_n = 1'b1;

        // Single entry, ack on the third request cycle.
        fixed_lat = 2;
        p0 = pops; r0 = req_cycles;
        push(32'h0000_1000, 32'hDEAD_BEEF, 0);
        run_until_idle(50, used);
        check("t2_pops", pops - p0, 1);
        check("t2_req_cycles", req_cycles - r0, 3);
        check("t2_wr_count", wr_count, 1);
        check("t2_drained", drained, 1);

        // Four entries with zero-wait acks: one store per two cycles.
        fixed_lat = 0;
        p0 = pops; w0 = wr_count;
        for (int i = 0; i < 4; i++) push(32'h2000 + 32'(i * 4), $urandom, 0);
        run_until_idle(50, used);
        check("t3_pops", pops - p0, 4);
        check("t3_cycles", used, 8);
        check("t3_wr_delta", wr_count - w0, 4);

        // Two failures then success: three request phases separated by backoff gaps.
        fixed_lat = 1;
        p0 = pops; r0 = req_cycles; w0 = wr_count;
        push(32'h3000, 32'h1234_5678, 2);
        run_until_idle(100, used);
        check("t4_pops", pops - p0, 1);
        check("t4_req_cycles", req_cycles - r0, 6);
        check("t4_wr_delta", wr_count - w0, 1);
        check("t4_drop_err", drop_err, 0);

        // Four failures drop the entry; the next one still goes through; err_clr clears the flag.
        fixed_lat = -1;
        w0 = wr_count;
        push(32'h4000, 32'hBAD0_0001, 4);
        push(32'h4004, 32'h600D_0002, 0);
        run_until_idle(150, used);
        check("t5_drop_err", drop_err, 1);
        check("t5_wr_delta", wr_count - w0, 1);
        err_clr = 1'b1;
        cycle();
        check("t5_err_clr", drop_err, 0);

        // Randomized traffic: pause, err_clr, retries, drops and stray acks.
        for (int i = 0; i < 600; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) begin
                int r;
                r = int'($urandom_range(0, 9));
                push($urandom, $urandom, (r < 6) ? 0 : r - 5);
            end
            pause   = ($urandom_range(0, 7) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        pause = 1'b0;
        run_until_idle(500, used);

        // Pause holds off pops; reset during a write clears everything at once.
        pause = 1'b1;
        p0 = pops;
        push(32'h5000, 32'hAAAA_5555, 0);
        push(32'h5004, 32'h5555_AAAA, 0);
        repeat (6) cycle();
        check("t6_pause_pops", pops - p0, 0);
        check("t6_pause_busy", busy, 0);
        pause = 1'b0;
        fixed_lat = 10;
        cycle();
        check("t6_req_up", bus.mem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_req", bus.mem_req, 0);
        check("t6_rst_we", bus.mem_we, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pop", fifo_pop, 0);
        check("t6_rst_addr", bus.mem_addr, 0);
        check("t6_rst_wdata", bus.mem_wdata, 0);
        check("t6_rst_wr_count", wr_count, 0);
        check("t6_rst_drop_err", drop_err, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
        fixed_lat = -1;
        run_until_idle(50, used);
        check("t6_after_wr_count", wr_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
